// File: rtl/parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_rx
// Purpose  : Serial frame receiver with even/odd parity checking.
//            Frame = start(0), DATA_W data bits LSB-first, parity, stop(1).
//            Each bit is sampled at its midpoint. Reports the data word, the
//            parity status and the stop-bit status with a one-cycle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module parity_frame_rx #(
    parameter int DATA_W       = 3,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 0) ? $clog2(DATA_W + 1) : 1;

    // Counter value seen at the edge that lands on a bit midpoint (START)
    // and one full bit later (all following bits).
    localparam logic [CW-1:0] H_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t            state_q,     state_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic [BW-1:0]     bit_q,       bit_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic              mode_q,      mode_d;
    logic              perr_pend_q, perr_pend_d;
    logic [DATA_W-1:0] data_out_q,  data_out_d;
    logic              valid_q,     valid_d;
    logic              perr_q,      perr_d;
    logic              ferr_q,      ferr_d;

    // New serial bit enters at the MSB so the first bit ends up in bit 0;
    // the extended vector keeps this legal for a single-bit word.
    logic [DATA_W:0]   shift_ext;
    logic [DATA_W-1:0] shift_nxt;

    assign shift_ext = {rx_in, shift_q};
    assign shift_nxt = shift_ext[DATA_W:1];

    // Next-state, counters, shift register and status updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        mode_d      = mode_q;
        perr_pend_d = perr_pend_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_in) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == H_LAST) begin
                    cnt_d = '0;
                    if (rx_in) begin
                        // Start bit did not survive to mid-bit: glitch.
                        state_d = S_IDLE;
                    end else begin
                        mode_d  = x;
                        bit_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == C_LAST) begin
                    shift_d = shift_nxt;
                    if (bit_q == B_LAST) begin
                        bit_d   = '0;
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == C_LAST) begin
                    // Non-zero when data ones + parity bit do not match mode.
                    perr_pend_d = (^shift_q) ^ rx_in ^ mode_q;
                    state_d     = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == C_LAST) begin
                    valid_d    = 1'b1;
                    data_out_d = shift_q;
                    perr_d     = perr_pend_q;
                    ferr_d     = ~rx_in;
                    state_d    = rx_in ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                // Hold off start detection until the line returns high.
                cnt_d = '0;
                if (rx_in) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            mode_q      <= 1'b0;
            perr_pend_q <= 1'b0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            mode_q      <= mode_d;
            perr_pend_q <= perr_pend_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_frame_rx
// Purpose  : Self-checking bench for parity_frame_rx. Frames come from a
//            vector table; expected results are queued when a frame is sent
//            and compared when the receiver strobes data_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_frame_rx;

    localparam int DATA_W = 3;
    localparam int CPB    = 4;
    localparam int H      = CPB / 2;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              x     = 1'b0;
    logic              rx_in = 1'b1;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    parity_frame_rx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              perr;
        logic              ferr;
        int                vcyc;
    } exp_t;

    typedef struct {
        logic              xm;
        logic [DATA_W-1:0] data;
        logic              p;
        logic              stop;
        logic              tog;
        logic              eperr;
        logic              eferr;
    } vec_t;

    exp_t sb[$];
    int   vtimes[$];
    int   errors = 0;
    int   checks = 0;

    logic [DATA_W-1:0] last_data = '0;
    logic              last_perr = 1'b0;
    logic              last_ferr = 1'b0;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every data_valid strobe must match the oldest queued frame.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_data_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("data_out",    32'(data_out),   32'(e.data));
                chk("parity_err",  32'(parity_err), 32'(e.perr));
                chk("frame_err",   32'(frame_err),  32'(e.ferr));
                chk("valid_cycle", 32'(cyc),        32'(e.vcyc));
                last_data = e.data;
                last_perr = e.perr;
                last_ferr = e.ferr;
                vtimes.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        rx_in = v;
        tick(CPB);
    endtask

    // The start bit is first sampled on the next edge (frame cycle 0); the
    // strobe is visible during cycle H + (DATA_W+2)*C + 1 of the frame.
    task automatic send_frame(input vec_t v);
        exp_t e;
        x      = v.xm;
        e.data = v.data;
        e.perr = v.eperr;
        e.ferr = v.eferr;
        e.vcyc = cyc + 1 + H + (DATA_W + 2) * CPB;
        sb.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) begin
            if (v.tog && i == 1) x = ~x;
            send_bit(v.data[i]);
        end
        send_bit(v.p);
        send_bit(v.stop);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //            x     data    p     stop  tog   perr  ferr
        tbl[0] = '{1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        rst   = 1'b1;
        rx_in = 1'b1;
        tick(3);
        chk("rst_data_out",   32'(data_out),   32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_frame_err",  32'(frame_err),  32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        rst = 1'b0;
        tick(3);

        // Good even, good odd, parity error with mid-frame mode toggle
        for (int i = 0; i < 3; i++) begin
            send_frame(tbl[i]);
            rx_in = 1'b1;
            tick(3);
        end

        // Framing error: line stays low after the stop slot
        send_frame(tbl[3]);
        for (int i = 0; i < 3; i++) begin
            chk("busy_held_low", 32'(busy), 32'd1);
            tick(1);
        end
        rx_in = 1'b1;
        tick(2);
        chk("busy_after_release", 32'(busy), 32'd0);

        // Recovery frame clears frame_err, then two more table vectors
        for (int i = 4; i < 7; i++) begin
            send_frame(tbl[i]);
            rx_in = 1'b1;
            tick(3);
        end

        // Start glitch shorter than half a bit
        rx_in = 1'b0;
        tick(1);
        rx_in = 1'b1;
        tick(H + 1);
        chk("glitch_busy", 32'(busy), 32'd0);
        tick(CPB * 6);
        chk("glitch_data_out",   32'(data_out),   32'(last_data));
        chk("glitch_parity_err", 32'(parity_err), 32'(last_perr));
        chk("glitch_frame_err",  32'(frame_err),  32'(last_ferr));

        // Reset in the middle of the data bits aborts the frame
        x = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("midframe_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("midrst_data_out",   32'(data_out),   32'd0);
        chk("midrst_data_valid", 32'(data_valid), 32'd0);
        chk("midrst_parity_err", 32'(parity_err), 32'd0);
        chk("midrst_frame_err",  32'(frame_err),  32'd0);
        chk("midrst_busy",       32'(busy),       32'd0);
        rst   = 1'b0;
        rx_in = 1'b1;
        tick(CPB * 8);

        // Back-to-back frames with no idle gap
        send_frame(tbl[7]);
        send_frame(tbl[8]);
        rx_in = 1'b1;
        tick(6);
        if (vtimes.size() >= 2) begin
            chk("b2b_spacing", 32'(vtimes[vtimes.size()-1] - vtimes[vtimes.size()-2]),
                32'((DATA_W + 3) * CPB));
        end else begin
            chk("b2b_pulse_count", 32'(vtimes.size()), 32'd2);
        end

        chk("pending_frames", 32'(sb.size()), 32'd0);
        chk("total_valid_pulses", 32'(vtimes.size()), 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
